mips_mdu: RTL and testbench



---
 rtl/mdu_pkg.sv | 22 ++
 rtl/mdu_arith.sv | 47 ++++
 rtl/mips_mdu.sv | 129 ++++++++++++
 tb/tb_mips_mdu.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/mdu_pkg.sv
// Shared definitions for the multiply/divide unit and the pipeline decoder.
// Holds the operation codes, the controller state encoding and the op field width.
package mdu_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NONE  = 3'd0,
    OP_MULT  = 3'd1,
    OP_MULTU = 3'd2,
    OP_DIV   = 3'd3,
    OP_DIVU  = 3'd4,
    OP_MTHI  = 3'd5,
    OP_MTLO  = 3'd6
  } mdu_op_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

endpackage

// File: rtl/mdu_arith.sv
// Combinational datapath for the MDU: signed/unsigned products, quotients and remainders.
// Signed division works on magnitudes, so MIN / -1 wraps back to MIN with a zero remainder.
module mdu_arith #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] prod_s,
  output logic [2*WIDTH-1:0] prod_u,
  output logic [WIDTH-1:0]   quot_s,
  output logic [WIDTH-1:0]   rem_s,
  output logic [WIDTH-1:0]   quot_u,
  output logic [WIDTH-1:0]   rem_u,
  output logic               div_zero
);

  logic [2*WIDTH-1:0] a_sx, b_sx, a_zx, b_zx;
  logic [WIDTH-1:0]   mag_a, mag_b, safe_b, safe_mag_b, q_mag, r_mag;
  logic               neg_a, neg_b;

  assign neg_a = a[WIDTH-1];
  assign neg_b = b[WIDTH-1];

  // Low 2*WIDTH bits of a product of sign-extended operands equal the signed product.
  assign a_sx   = {{WIDTH{neg_a}}, a};
  assign b_sx   = {{WIDTH{neg_b}}, b};
  assign a_zx   = {{WIDTH{1'b0}}, a};
  assign b_zx   = {{WIDTH{1'b0}}, b};
  assign prod_s = a_sx * b_sx;
  assign prod_u = a_zx * b_zx;

  // A zero divisor is replaced by one so the dividers never see it; the result is discarded anyway.
  assign div_zero   = (b == '0);
  assign safe_b     = div_zero ? WIDTH'(1) : b;
  assign mag_a      = neg_a ? -a : a;
  assign mag_b      = neg_b ? -b : b;
  assign safe_mag_b = div_zero ? WIDTH'(1) : mag_b;

  assign q_mag  = mag_a / safe_mag_b;
  assign r_mag  = mag_a % safe_mag_b;
  assign quot_s = (neg_a ^ neg_b) ? -q_mag : q_mag;
  assign rem_s  = neg_a ? -r_mag : r_mag;

  assign quot_u = a / safe_b;
  assign rem_u  = a % safe_b;

endmodule

// File: rtl/mips_mdu.sv
// Multi-cycle multiply/divide unit owning the HI/LO pair, with busy for the hazard unit.
// Results are computed at issue, parked in p_hi/p_lo and committed when the down-counter expires.
module mips_mdu
  import mdu_pkg::*;
#(
  parameter int WIDTH       = 32,
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CNT_MAX = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  mdu_state_e         state, state_n;
  logic [CNT_W-1:0]   cnt, cnt_n;
  logic [WIDTH-1:0]   p_hi, p_hi_n, p_lo, p_lo_n;
  logic               p_keep, p_keep_n;
  logic [WIDTH-1:0]   hi_n, lo_n;
  mdu_op_e            op_e;

  logic [2*WIDTH-1:0] prod_s, prod_u;
  logic [WIDTH-1:0]   quot_s, rem_s, quot_u, rem_u;
  logic               div_zero;

  mdu_arith #(.WIDTH(WIDTH)) u_arith (
    .a        (a),
    .b        (b),
    .prod_s   (prod_s),
    .prod_u   (prod_u),
    .quot_s   (quot_s),
    .rem_s    (rem_s),
    .quot_u   (quot_u),
    .rem_u    (rem_u),
    .div_zero (div_zero)
  );

  assign op_e = mdu_op_e'(op);
  assign busy = (state == ST_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= ST_IDLE;
      cnt    <= '0;
      p_hi   <= '0;
      p_lo   <= '0;
      p_keep <= 1'b0;
      hi     <= '0;
      lo     <= '0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      p_hi   <= p_hi_n;
      p_lo   <= p_lo_n;
      p_keep <= p_keep_n;
      hi     <= hi_n;
      lo     <= lo_n;
    end
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    p_hi_n   = p_hi;
    p_lo_n   = p_lo;
    p_keep_n = p_keep;
    hi_n     = hi;
    lo_n     = lo;
    unique case (state)
      ST_IDLE: begin
        if (start) begin
          case (op_e)
            OP_MULT: begin
              {p_hi_n, p_lo_n} = prod_s;
              p_keep_n = 1'b0;
              cnt_n    = CNT_W'(MULT_CYCLES);
              state_n  = ST_RUN;
            end
            OP_MULTU: begin
              {p_hi_n, p_lo_n} = prod_u;
              p_keep_n = 1'b0;
              cnt_n    = CNT_W'(MULT_CYCLES);
              state_n  = ST_RUN;
            end
            OP_DIV: begin
              p_hi_n   = rem_s;
              p_lo_n   = quot_s;
              p_keep_n = div_zero;
              cnt_n    = CNT_W'(DIV_CYCLES);
              state_n  = ST_RUN;
            end
            OP_DIVU: begin
              p_hi_n   = rem_u;
              p_lo_n   = quot_u;
              p_keep_n = div_zero;
              cnt_n    = CNT_W'(DIV_CYCLES);
              state_n  = ST_RUN;
            end
            OP_MTHI: hi_n = a;
            OP_MTLO: lo_n = a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_n = cnt - CNT_W'(1);
        if (cnt == CNT_W'(1)) begin
          // Divide by zero runs the full duration but leaves HI/LO untouched.
          if (!p_keep) begin
            hi_n = p_hi;
            lo_n = p_lo;
          end
          state_n = ST_IDLE;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_mips_mdu.sv
// Self-checking bench for mips_mdu: directed corner cases plus random ops against an arithmetic model.
// A second instance with single-cycle latency runs the same op stream.
module tb_mips_mdu;
  import mdu_pkg::*;

  logic        clk = 1'b0;
  logic        reset, start, start1;
  logic [2:0]  op;
  logic [31:0] a, b;
  logic        busy, busy1;
  logic [31:0] hi, lo, hi1, lo1;

  int checks   = 0;
  int failures = 0;
  logic [31:0] m_hi, m_lo;

  always #5 clk = ~clk;

  mips_mdu #(.WIDTH(32), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op), .a(a), .b(b),
    .busy(busy), .hi(hi), .lo(lo)
  );

  mips_mdu #(.WIDTH(32), .MULT_CYCLES(1), .DIV_CYCLES(1)) dut1 (
    .clk(clk), .reset(reset), .start(start1), .op(op), .a(a), .b(b),
    .busy(busy1), .hi(hi1), .lo(lo1)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int occupancy(input logic [2:0] o);
    case (o)
      3'd1, 3'd2: return 5;
      3'd3, 3'd4: return 10;
      default:    return 0;
    endcase
  endfunction

  task automatic model(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    longint          ps;
    longint unsigned pu;
    int              q, r;
    case (o)
      3'd1: begin
        ps = longint'($signed(x)) * longint'($signed(y));
        m_hi = ps[63:32];
        m_lo = ps[31:0];
      end
      3'd2: begin
        pu = longint'({32'd0, x}) * longint'({32'd0, y});
        m_hi = pu[63:32];
        m_lo = pu[31:0];
      end
      3'd3: begin
        if (y != 0) begin
          if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) begin
            m_lo = x;
            m_hi = 0;
          end else begin
            q = $signed(x) / $signed(y);
            r = $signed(x) % $signed(y);
            m_lo = q;
            m_hi = r;
          end
        end
      end
      3'd4: begin
        if (y != 0) begin
          m_lo = x / y;
          m_hi = x % y;
        end
      end
      3'd5: m_hi = x;
      3'd6: m_lo = x;
      default: ;
    endcase
  endtask

  task automatic run_op(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
    logic [31:0] old_hi;
    int n, exp_n;
    old_hi = m_hi;
    exp_n  = occupancy(o);
    @(negedge clk);
    op = o; a = x; b = y; start = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; start1 = 1'b0;
    a = $urandom; b = $urandom;
    model(o, x, y);
    if (exp_n != 0) check("busy1_on", {31'd0, busy1}, 32'd1);
    n = 0;
    while (busy && n < 40) begin
      n++;
      if (n == 1) check("hi_early", hi, old_hi);
      @(posedge clk); #1;
      if (n == 1) check("busy1_off", {31'd0, busy1}, 32'd0);
    end
    check("busy_len", 32'(n), 32'(exp_n));
    check("hi", hi, m_hi);
    check("lo", lo, m_lo);
    check("hi1", hi1, m_hi);
    check("lo1", lo1, m_lo);
  endtask

  initial begin
    int n;
    logic [2:0]  ro;
    logic [31:0] ra, rb;
    reset = 1'b1; start = 1'b0; start1 = 1'b0; op = 3'd0; a = 0; b = 0;
    m_hi = 0; m_lo = 0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    @(negedge clk) reset = 1'b0;

    run_op(OP_MULT, 32'hFFFF_FFFE, 32'd3);
    check("mult_hi_const", hi, 32'hFFFF_FFFF);
    check("mult_lo_const", lo, 32'hFFFF_FFFA);
    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check("multu_hi_const", hi, 32'hFFFF_FFFE);
    run_op(OP_DIVU, 32'd7, 32'd2);
    check("divu_lo_const", lo, 32'd3);
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    check("div_lo_const", lo, 32'hFFFF_FFFD);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    check("div_min_hi_const", hi, 32'd0);
    run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9);
    run_op(OP_MTHI, 32'h1234, 32'd0);
    run_op(OP_MTLO, 32'h5678, 32'd0);
    run_op(OP_DIV, 32'd99, 32'd0);
    check("dz_hi_const", hi, 32'h1234);
    check("dz_lo_const", lo, 32'h5678);
    run_op(OP_DIVU, 32'hFFFF_0000, 32'd0);
    run_op(OP_NONE, 32'hAAAA_AAAA, 32'd1);
    run_op(3'd7, 32'hBBBB_BBBB, 32'd1);

    // MTHI presented while both instances are running must be dropped.
    @(negedge clk);
    op = OP_MULT; a = 32'd1000; b = 32'hFFFF_FFF0; start = 1'b1; start1 = 1'b1;
    @(posedge clk); #1;
    model(OP_MULT, 32'd1000, 32'hFFFF_FFF0);
    start1 = 1'b0; op = OP_MTHI; a = 32'hDEAD_BEEF;
    @(posedge clk); #1;
    start = 1'b0;
    n = 0;
    while (busy && n < 40) begin
      n++;
      @(posedge clk); #1;
    end
    check("viol_len", 32'(n), 32'd4);
    check("viol_hi", hi, m_hi);
    check("viol_lo", lo, m_lo);
    check("viol_hi1", hi1, m_hi);

    // Reset in the middle of a multiply discards it.
    @(negedge clk);
    op = OP_MULT; a = 32'd12345; b = 32'd678; start = 1'b1; start1 = 1'b1;
    @(posedge clk);
    @(negedge clk) begin start = 1'b0; start1 = 1'b0; end
    @(posedge clk);
    @(negedge clk) reset = 1'b1;
    @(posedge clk); #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_hi", hi, 32'd0);
    check("midrst_lo", lo, 32'd0);
    check("midrst_busy1", {31'd0, busy1}, 32'd0);
    @(negedge clk) reset = 1'b0;
    m_hi = 0; m_lo = 0;
    repeat (3) @(posedge clk);
    #1;
    check("post_rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 30; i++) begin
      ro = 3'($urandom_range(0, 7));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: begin ra = 32'h8000_0000; rb = 32'hFFFF_FFFF; end
        2: rb = 32'($urandom_range(1, 20));
        default: ;
      endcase
      run_op(ro, ra, rb);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
